mac_operand_fifo: RTL

//  Operand staging buffer at the MAC input. It holds a 4-entry circular buffer with a

---
 rtl/mac_operand_fifo.sv | 104 ++++++++++
 1 files changed

// File: rtl/mac_operand_fifo.sv
// mac_operand_fifo
//   Operand staging buffer at the MAC input: a 4-entry circular buffer with a
//   valid/ready handshake on both sides. Full and empty are told apart when the
//   pointers are equal by a local wrap bit (Round) that is set when the tail
//   wraps and cleared when the head wraps.
//
// Ports
//   clk              in   single clock, all state changes on the rising edge
//   reset            in   synchronous, active-low
//   in_data          in   operand word from upstream
//   in_valid         in   upstream has a word on in_data
//   in_ready         out  buffer can accept a word (not full)
//   out_data         out  word in the head slot (combinational read)
//   out_valid        out  buffer holds at least one word (not empty)
//   out_ready        in   MAC datapath takes the head word
//   TP               out  tail (write) pointer
//   HP               out  head (read) pointer
//   Round            out  wrap bit: tail has wrapped and head has not yet
//   Rec_Handshaking  out  push strobe, combinational
//   Send_Handshaking out  pop strobe, combinational
//   count            out  occupancy, 0..4
//   ovf_err          out  sticky flag: in_valid was presented while full
module mac_operand_fifo #(
    parameter int DATA_W = 16,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PTR_W-1:0]  TP,
    output logic [PTR_W-1:0]  HP,
    output logic              Round,
    output logic              Rec_Handshaking,
    output logic              Send_Handshaking,
    output logic [PTR_W:0]    count,
    output logic              ovf_err
);

    localparam int             DEPTH   = 1 << PTR_W;
    localparam logic [PTR_W:0] DEPTH_W = DEPTH[PTR_W:0];
    localparam logic [PTR_W-1:0] LAST  = '1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              ptr_eq;
    logic              full;
    logic              empty;
    logic              round_next;

    assign ptr_eq = (TP == HP);
    assign full   = ptr_eq & Round;
    assign empty  = ptr_eq & ~Round;

    assign in_ready         = ~full;
    assign out_valid        = ~empty;
    assign Rec_Handshaking  = in_valid & in_ready;
    assign Send_Handshaking = out_valid & out_ready;

    // Zero-latency head: a word is visible the cycle after it is written.
    assign out_data = mem[HP];

    // When Round is set the tail is one lap ahead of the head.
    assign count = Round ? (DEPTH_W - {1'b0, HP} + {1'b0, TP})
                         : ({1'b0, TP} - {1'b0, HP});

    // Clear on head wrap is applied first so that a tail wrap in the same
    // cycle (set) wins.
    always_comb begin
        round_next = Round;
        if (Send_Handshaking && (HP == LAST))
            round_next = 1'b0;
        if (Rec_Handshaking && (TP == LAST))
            round_next = 1'b1;
    end

    // Storage is never cleared; reset only discards contents logically by
    // returning the pointers to the empty state.
    always_ff @(posedge clk) begin
        if (reset && Rec_Handshaking)
            mem[TP] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            TP      <= '0;
            HP      <= '0;
            Round   <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            if (Rec_Handshaking)
                TP <= TP + 1'b1;
            if (Send_Handshaking)
                HP <= HP + 1'b1;
            Round <= round_next;
            if (in_valid && full)
                ovf_err <= 1'b1;
        end
    end

endmodule
